axi4_frame_master: RTL and testbench
====================================

Name: axi4_frame_master

Overview:
- Parametrised AXI4 burst master between the write/read pixel FIFOs and the DDR3 MIG AXI slave.
- Write and read channels run independently. Each moves fixed-length INCR bursts on a trigger.
- Frames are stored in NUM_BUF frame buffers; the read side always scans the most recently completed write frame. This gives tear-free double/triple buffering for the HDMI display path.
- Adds write-response error reporting and frame-done/frame-start strobes.

Parameters:
- DATA_W, 128, AXI data width in bits (64/128/256).
- ADDR_W, 28, AXI address width.
- BURST_LEN, 16, beats per burst (1..256); awlen/arlen = BURST_LEN-1.
- FRAME_BYTES, 4147200, bytes per frame; must be a multiple of BB = BURST_LEN*DATA_W/8.
- NUM_BUF, 3, number of frame buffers (1..4).
- FRAME_BASE, 0, byte address of buffer 0.
- FRAME_STRIDE, 4194304, byte distance between buffers; must be >= FRAME_BYTES.

Ports:
- sclk in 1: AXI/user clock.
- s_rst_n in 1: asynchronous active-low reset.
- m_axi_aw{id 4, addr ADDR_W, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4} out: write address fields.
- m_axi_awvalid out 1; m_axi_awready in 1.
- m_axi_wdata out DATA_W; m_axi_wstrb out DATA_W/8; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1.
- m_axi_bid in 4; m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
- m_axi_ar{id, addr, len, size, burst, lock, cache, prot, qos} out: same widths as AW.
- m_axi_arvalid out 1; m_axi_arready in 1.
- m_axi_rid in 4; m_axi_rdata in DATA_W; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1.
- wr_trig in 1: pulse, at least one burst of data available in the write FIFO.
- wfifo_rd_en out 1; wfifo_rd_data in DATA_W (FWFT).
- rd_trig in 1: pulse, room for one burst in the read FIFO.
- rfifo_wr_en out 1; rfifo_wr_data out DATA_W.
- wr_frame_done out 1: 1-cycle pulse.
- rd_frame_start out 1: 1-cycle pulse.
- wr_err out 1: 1-cycle pulse.
- wr_err_cnt out 8: saturating count of write-response errors.

Behaviour:
- Constant fields:
  - id = 0, len = BURST_LEN-1, size = log2(DATA_W/8), burst = INCR (1).
  - lock/cache/prot/qos = 0; wstrb all ones.
- Reset: every valid/ready output, both FSMs and all counters and pulses = 0.
  - Offsets = 0; wr_buf = 0; rd_buf = 0; last_buf = 0; last_valid = 0.
- Address: FRAME_BASE + buf*FRAME_STRIDE + offset, computed in ADDR_W bits.
- Write FSM W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
  - W_IDLE: wr_trig=1 registers awvalid=1 and wvalid=1 the next cycle and enters W_XFER. wr_trig in any other state is ignored (not queued).
  - W_XFER: awvalid clears on AW handshake. Beat counter increments per W handshake; wlast = (beat == BURST_LEN-1).
  - wvalid clears on the wlast handshake. W may complete before AW.
  - Leave W_XFER only when both AW and the last W have handshaked. Then bready=1 and enter W_RESP.
  - W_RESP: on B handshake, bready=0 and return to W_IDLE.
  - wfifo_rd_en = wvalid & wready (combinational); wdata = wfifo_rd_data.
- Write offset advances by BB on the B handshake.
  - If offset was FRAME_BYTES-BB: offset becomes 0, wr_frame_done pulses, last_buf = wr_buf, last_valid = 1.
  - wr_buf advances to (wr_buf+1) mod NUM_BUF. If that equals rd_buf and NUM_BUF>=3, advance once more. With NUM_BUF<=2 no skip is done.
- bresp != 0 on B handshake: wr_err pulses for 1 cycle and wr_err_cnt increments, saturating at 255. The burst is still counted as done (no retry).
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: rd_trig=1 registers arvalid=1 and enters R_ADDR.
  - If rd offset == 0 at that moment: rd_buf = last_buf and rd_frame_start pulses. If last_valid=0, rd_buf stays 0.
  - R_ADDR: on AR handshake, arvalid=0, rready=1, enter R_DATA, and offset advances by BB (wraps to 0 after FRAME_BYTES-BB).
  - R_DATA: on an R handshake with rlast, rready=0 and return to R_IDLE.
  - rfifo_wr_en = rvalid & rready; rfifo_wr_data = rdata.
- Simultaneous events:
  - rd frame start in the same cycle as wr frame done: rd latches the new last_buf (bypass).
  - The wr_buf skip compares against the post-update rd_buf.
- Read and write channels never stall each other.
- Reset mid-burst aborts immediately; no outstanding-transaction tracking is kept.

Test Plan:
- FRAME_BYTES=1024, BURST_LEN=16, DATA_W=128, NUM_BUF=3, FRAME_BASE=0x100000, FRAME_STRIDE=0x400000:
  - 4 wr_trig bursts -> awaddr 0x100000, 0x100100, 0x100200, 0x100300.
  - Exactly 16 wfifo_rd_en per burst; wlast on beat 16; wr_frame_done after the 4th B; next awaddr 0x500000.
- Slave asserts wready 3 cycles before awready -> all 16 beats accepted, AW later, bready only after both; no extra wfifo_rd_en.
- After write frame 0 completes, rd_trig -> rd_frame_start, araddr 0x100000.
  - Write buffer sequence with the read holding buffer 0 ... the write skips rd_buf: 1 -> 2 -> 1.
- bresp=2'b10 on one burst -> wr_err 1-cycle pulse, wr_err_cnt=1, offset still advances. 300 errors -> wr_err_cnt=255.
- wr_trig/rd_trig held high continuously -> one transaction in flight per channel; 16 rfifo_wr_en per read burst; arvalid never reasserts before rlast.
- s_rst_n low mid-W_XFER (beat 7) -> all valids/readies 0 within the reset, offsets 0; first burst after release at 0x100000.

Source files
------------

// File: rtl/axi4_frame_master.sv
// AXI4 burst master moving fixed-length INCR bursts between the pixel FIFOs and the
// DDR3 controller. Write and read channels run independently over NUM_BUF frame buffers.
// The reader always picks up the most recently completed write frame.
module axi4_frame_master #(
  parameter int unsigned DATA_W       = 128,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_BYTES  = 4147200,
  parameter int unsigned NUM_BUF      = 3,
  parameter int unsigned FRAME_BASE   = 0,
  parameter int unsigned FRAME_STRIDE = 4194304
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  output logic [3:0]          m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [3:0]          m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [3:0]          m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [3:0]          m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                wr_trig,
  output logic                wfifo_rd_en,
  input  logic [DATA_W-1:0]   wfifo_rd_data,
  input  logic                rd_trig,
  output logic                rfifo_wr_en,
  output logic [DATA_W-1:0]   rfifo_wr_data,
  output logic                wr_frame_done,
  output logic                rd_frame_start,
  output logic                wr_err,
  output logic [7:0]          wr_err_cnt
);

  localparam int unsigned       BB       = BURST_LEN * DATA_W / 8;
  localparam logic [ADDR_W-1:0] BB_A     = ADDR_W'(BB);
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(FRAME_BYTES - BB);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(FRAME_STRIDE);
  localparam logic [7:0]        LEN      = 8'(BURST_LEN - 1);
  localparam logic [2:0]        SIZE     = 3'($clog2(DATA_W / 8));
  localparam logic [1:0]        NB_M1    = 2'(NUM_BUF - 1);

  typedef enum logic [1:0] {WIdle, WXfer, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

  wr_state_e         r_wst, w_wst_nxt;
  rd_state_e         r_rst, w_rst_nxt;
  logic              r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt, r_bready, w_bready_nxt;
  logic              r_arvalid, w_arvalid_nxt, r_rready, w_rready_nxt;
  logic [7:0]        r_wbeat, w_wbeat_nxt;
  logic [ADDR_W-1:0] r_wr_off, w_wr_off_nxt, r_rd_off, w_rd_off_nxt;
  logic [1:0]        r_wr_buf, w_wr_buf_nxt, r_rd_buf, w_rd_buf_nxt;
  logic [1:0]        r_last_buf, w_last_buf_nxt, w_buf_step;
  logic              r_last_valid, w_last_valid_nxt;
  logic              r_frame_done, w_frame_done_nxt, r_wr_err, w_wr_err_nxt;
  logic              r_rd_start, w_rd_start_nxt;
  logic [7:0]        r_err_cnt, w_err_cnt_nxt;
  logic              w_wr_wrap, w_wlast, w_w_hs;
  logic              w_unused;

  function automatic logic [1:0] buf_inc(input logic [1:0] b);
    return (b == NB_M1) ? 2'd0 : b + 2'd1;
  endfunction

  assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_rresp};

  assign m_axi_awid    = 4'd0;
  assign m_axi_awlen   = LEN;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'd1;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_arid    = 4'd0;
  assign m_axi_arlen   = LEN;
  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = 2'd1;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;

  assign m_axi_awaddr  = BASE_A + {{(ADDR_W-2){1'b0}}, r_wr_buf} * STRIDE_A + r_wr_off;
  assign m_axi_araddr  = BASE_A + {{(ADDR_W-2){1'b0}}, r_rd_buf} * STRIDE_A + r_rd_off;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = wfifo_rd_data;
  assign w_wlast       = (r_wbeat == LEN);
  assign m_axi_wlast   = w_wlast;
  assign w_w_hs        = r_wvalid & m_axi_wready;
  assign wfifo_rd_en   = w_w_hs;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign rfifo_wr_en   = m_axi_rvalid & r_rready;
  assign rfifo_wr_data = m_axi_rdata;
  assign wr_frame_done  = r_frame_done;
  assign rd_frame_start = r_rd_start;
  assign wr_err         = r_wr_err;
  assign wr_err_cnt     = r_err_cnt;

  // Write FSM next state, beat counting, offset/frame bookkeeping and error counting
  always_comb begin
    w_wst_nxt        = r_wst;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_wbeat_nxt      = r_wbeat;
    w_wr_off_nxt     = r_wr_off;
    w_frame_done_nxt = 1'b0;
    w_wr_err_nxt     = 1'b0;
    w_err_cnt_nxt    = r_err_cnt;
    w_last_buf_nxt   = r_last_buf;
    w_last_valid_nxt = r_last_valid;
    w_wr_wrap        = 1'b0;
    unique case (r_wst)
      WIdle: begin
        if (wr_trig) begin
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_wbeat_nxt   = 8'd0;
          w_wst_nxt     = WXfer;
        end
      end
      WXfer: begin
        if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
        if (w_w_hs) begin
          w_wbeat_nxt = w_wlast ? 8'd0 : r_wbeat + 8'd1;
          if (w_wlast) w_wvalid_nxt = 1'b0;
        end
        // AW and the last W beat may finish in either order; wait for both
        if ((!r_awvalid || m_axi_awready) && (!r_wvalid || (m_axi_wready && w_wlast))) begin
          w_bready_nxt = 1'b1;
          w_wst_nxt    = WResp;
        end
      end
      WResp: begin
        if (m_axi_bvalid && r_bready) begin
          w_bready_nxt = 1'b0;
          w_wst_nxt    = WIdle;
          if (m_axi_bresp != 2'd0) begin
            w_wr_err_nxt = 1'b1;
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
          end
          if (r_wr_off == LAST_OFF) begin
            w_wr_off_nxt     = '0;
            w_frame_done_nxt = 1'b1;
            w_last_buf_nxt   = r_wr_buf;
            w_last_valid_nxt = 1'b1;
            w_wr_wrap        = 1'b1;
          end else begin
            w_wr_off_nxt = r_wr_off + BB_A;
          end
        end
      end
      default: w_wst_nxt = WIdle;
    endcase
  end

  // Read FSM next state; a frame start picks up this cycle's completed frame (bypass)
  always_comb begin
    w_rst_nxt      = r_rst;
    w_arvalid_nxt  = r_arvalid;
    w_rready_nxt   = r_rready;
    w_rd_off_nxt   = r_rd_off;
    w_rd_buf_nxt   = r_rd_buf;
    w_rd_start_nxt = 1'b0;
    unique case (r_rst)
      RIdle: begin
        if (rd_trig) begin
          w_arvalid_nxt = 1'b1;
          w_rst_nxt     = RAddr;
          if (r_rd_off == '0) begin
            w_rd_start_nxt = 1'b1;
            if (w_last_valid_nxt) w_rd_buf_nxt = w_last_buf_nxt;
          end
        end
      end
      RAddr: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_rst_nxt     = RData;
          w_rd_off_nxt  = (r_rd_off == LAST_OFF) ? '0 : r_rd_off + BB_A;
        end
      end
      RData: begin
        if (m_axi_rvalid && m_axi_rlast) begin
          w_rready_nxt = 1'b0;
          w_rst_nxt    = RIdle;
        end
      end
      default: w_rst_nxt = RIdle;
    endcase
  end

  // Next write buffer; with three or more buffers never land on the one being read
  always_comb begin
    w_buf_step   = buf_inc(r_wr_buf);
    w_wr_buf_nxt = r_wr_buf;
    if (w_wr_wrap) begin
      if ((NUM_BUF >= 3) && (w_buf_step == w_rd_buf_nxt)) w_wr_buf_nxt = buf_inc(w_buf_step);
      else w_wr_buf_nxt = w_buf_step;
    end
  end

  // Write-side state registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_wst        <= WIdle;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_wbeat      <= 8'd0;
      r_wr_off     <= '0;
      r_wr_buf     <= 2'd0;
      r_last_buf   <= 2'd0;
      r_last_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_wst        <= w_wst_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_wbeat      <= w_wbeat_nxt;
      r_wr_off     <= w_wr_off_nxt;
      r_wr_buf     <= w_wr_buf_nxt;
      r_last_buf   <= w_last_buf_nxt;
      r_last_valid <= w_last_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_wr_err     <= w_wr_err_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  // Read-side state registers
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_rst      <= RIdle;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rd_off   <= '0;
      r_rd_buf   <= 2'd0;
      r_rd_start <= 1'b0;
    end else begin
      r_rst      <= w_rst_nxt;
      r_arvalid  <= w_arvalid_nxt;
      r_rready   <= w_rready_nxt;
      r_rd_off   <= w_rd_off_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_rd_start <= w_rd_start_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_frame_master.sv
// Directed bench for axi4_frame_master: small 1 KiB frames, triple buffering.
module tb_axi4_frame_master;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 28;
  localparam int          BL = 16;

  logic          clk = 1'b0;
  logic          s_rst_n;
  logic [3:0]    awid, awcache, awqos, arid, arcache, arqos;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, awprot, arsize, arprot;
  logic [1:0]    awburst, arburst;
  logic          awlock, arlock;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata, wfifo_rd_data, rfifo_wr_data;
  logic [DW/8-1:0] wstrb;
  logic [3:0]    bid, rid;
  logic [1:0]    bresp, rresp;
  logic          wr_trig, rd_trig, wfifo_rd_en, rfifo_wr_en;
  logic          wr_frame_done, rd_frame_start, wr_err;
  logic [7:0]    wr_err_cnt;

  int n_checks = 0;
  int n_bad    = 0;
  int n_done   = 0;
  int n_start  = 0;
  int n_err    = 0;

  logic [AW-1:0] wb_addr, rb_addr;
  int            wb_nrd, wb_last, wb_naw, wb_dbad;
  bit            wb_early, wb_bstuck, wb_tmo;
  int            rb_nar, rb_nwr, rb_dbad;
  bit            rb_again, rb_tmo, rb_rstuck;
  int            lags[4] = '{0, 3, 20, 1};
  int            beats7;

  axi4_frame_master #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FRAME_BYTES(1024), .NUM_BUF(3),
    .FRAME_BASE(32'h0010_0000), .FRAME_STRIDE(32'h0040_0000)
  ) u_dut (
    .sclk(clk), .s_rst_n(s_rst_n),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .wr_trig(wr_trig), .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data),
    .rd_trig(rd_trig), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start), .wr_err(wr_err),
    .wr_err_cnt(wr_err_cnt)
  );

  always #5 clk = ~clk;

  // Count high cycles of each strobe; a 1-cycle pulse adds exactly one
  always @(negedge clk) begin
    if (wr_frame_done)  n_done  <= n_done + 1;
    if (rd_frame_start) n_start <= n_start + 1;
    if (wr_err)         n_err   <= n_err + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int b, input logic [31:0] salt);
    return {salt, salt ^ 32'(b), 32'(b), ~salt};
  endfunction

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // One write burst as the slave: AW accepted aw_lag cycles after W starts flowing
  task automatic wr_burst(input int aw_lag, input logic [1:0] resp, input bit hold);
    int beats;
    int cyc;
    beats = 0; wb_addr = '0; wb_nrd = 0; wb_last = 0; wb_naw = 0; wb_dbad = 0;
    @(negedge clk); wr_trig = 1'b1;
    @(negedge clk); if (!hold) wr_trig = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      awready = (cyc >= aw_lag);
      wready = 1'b1;
      wfifo_rd_data = pat(beats, 32'hA5A5_0000);
      #1;
      if (bready) break;
      if (awvalid && awready) begin wb_addr = awaddr; wb_naw++; end
      if (wfifo_rd_en) wb_nrd++;
      if (wvalid && wready) begin
        beats++;
        if (wlast) wb_last = beats;
        if (wdata !== wfifo_rd_data) wb_dbad++;
      end
      @(negedge clk);
    end
    wb_tmo = (cyc >= 200);
    wb_early = (wb_naw == 0) || (beats != BL);
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'd0;
    if (hold) wr_trig = 1'b0;
    #1;
    wb_bstuck = bready;
  endtask

  // One read burst as the slave: AR accepted ar_lag cycles after arvalid, then 16 beats
  task automatic rd_burst(input int ar_lag, input bit hold);
    int beats;
    int cyc;
    bit got_ar;
    beats = 0; got_ar = 1'b0; rb_addr = '0; rb_nar = 0; rb_nwr = 0; rb_dbad = 0;
    rb_again = 1'b0; rb_tmo = 1'b0;
    @(negedge clk); rd_trig = 1'b1;
    @(negedge clk); if (!hold) rd_trig = 1'b0;
    for (cyc = 0; cyc < 100 && !got_ar; cyc++) begin
      arready = (cyc >= ar_lag);
      #1;
      if (arvalid && arready) begin rb_addr = araddr; rb_nar++; got_ar = 1'b1; end
      @(negedge clk);
    end
    arready = 1'b0;
    if (!got_ar) rb_tmo = 1'b1;
    for (cyc = 0; cyc < 100 && beats < BL; cyc++) begin
      rvalid = 1'b1;
      rdata = pat(beats, 32'h5A5A_0000);
      rlast = (beats == BL - 1);
      #1;
      if (arvalid) rb_again = 1'b1;
      if (rfifo_wr_en) begin
        rb_nwr++;
        if (rfifo_wr_data !== rdata) rb_dbad++;
      end
      if (rvalid && rready) beats++;
      @(negedge clk);
    end
    if (beats < BL) rb_tmo = 1'b1;
    rvalid = 1'b0; rlast = 1'b0;
    if (hold) rd_trig = 1'b0;
    #1;
    rb_rstuck = rready;
  endtask

  task automatic chk_wr(input string tag);
    check({tag, "_nrd"}, 64'(wb_nrd), 64'd16);
    check({tag, "_wlast"}, 64'(wb_last), 64'd16);
    check({tag, "_naw"}, 64'(wb_naw), 64'd1);
    check({tag, "_bflags"}, {60'd0, wb_early, wb_bstuck, wb_tmo, (wb_dbad != 0)}, 64'd0);
  endtask

  task automatic chk_rd(input string tag);
    check({tag, "_nwr"}, 64'(rb_nwr), 64'd16);
    check({tag, "_nar"}, 64'(rb_nar), 64'd1);
    check({tag, "_rflags"}, {60'd0, rb_again, rb_rstuck, rb_tmo, (rb_dbad != 0)}, 64'd0);
  endtask

  initial begin
    s_rst_n = 1'b0;
    wr_trig = 1'b0; rd_trig = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0; bid = 4'd0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0; rid = 4'd0;
    rdata = '0; wfifo_rd_data = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_handshake", {57'd0, awvalid, wvalid, bready, arvalid, rready, wfifo_rd_en,
                            rfifo_wr_en}, 64'd0);
    check("rst_pulses", {53'd0, wr_frame_done, rd_frame_start, wr_err, wr_err_cnt}, 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'h10_0000);
    s_rst_n = 1'b1;
    check("aw_const", {35'd0, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos},
          {35'd0, 4'd0, 8'd15, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0});
    check("ar_const", {35'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos},
          {35'd0, 4'd0, 8'd15, 3'd4, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0});
    check("wstrb", 64'(wstrb), 64'hFFFF);

    // Frame 0 in buffer 0, AW accepted early, late and very late relative to W
    for (int i = 0; i < 4; i++) begin
      wr_burst(lags[i], 2'd0, 1'b0);
      check($sformatf("f0_addr%0d", i), 64'(wb_addr), 64'h10_0000 + 64'(i) * 64'h100);
      chk_wr($sformatf("f0_b%0d", i));
    end
    settle();
    check("f0_done", 64'(n_done), 64'd1);

    // Reader starts on the frame just finished
    rd_burst(2, 1'b0);
    settle();
    check("rd0_addr", 64'(rb_addr), 64'h10_0000);
    check("rd0_start", 64'(n_start), 64'd1);
    chk_rd("rd0");

    // Frames 1 and 2 go to buffers 1 and 2; frame 3 skips buffer 0 (held by reader)
    for (int f = 1; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        wr_burst(0, 2'd0, 1'b0);
        if (i == 0) check($sformatf("f%0d_addr", f), 64'(wb_addr),
                          (f == 1) ? 64'h50_0000 : 64'h90_0000);
      end
    end
    settle();
    check("f2_done", 64'(n_done), 64'd3);
    wr_burst(0, 2'd0, 1'b0);
    check("f3_addr", 64'(wb_addr), 64'h50_0000);

    // Error response still advances the offset
    wr_burst(0, 2'b10, 1'b0);
    check("err_addr", 64'(wb_addr), 64'h50_0100);
    chk_wr("err_b");
    settle();
    check("err_pulse", 64'(n_err), 64'd1);
    check("err_cnt1", 64'(wr_err_cnt), 64'd1);
    wr_burst(0, 2'd0, 1'b0);
    check("post_err_addr", 64'(wb_addr), 64'h50_0200);
    settle();
    check("err_cnt_ok", 64'(wr_err_cnt), 64'd1);
    for (int i = 0; i < 299; i++) wr_burst(0, 2'b10, 1'b0);
    settle();
    check("err_sat", 64'(wr_err_cnt), 64'd255);
    check("err_pulses", 64'(n_err), 64'd300);

    // Both triggers held high, channels running concurrently
    fork
      wr_burst(2, 2'd0, 1'b1);
      rd_burst(1, 1'b1);
    join
    chk_wr("hold_w");
    chk_rd("hold_r");
    check("hold_araddr", 64'(rb_addr), 64'h10_0100);
    settle();
    check("hold_idle", {62'd0, awvalid, arvalid}, 64'd0);
    check("hold_nostart", 64'(n_start), 64'd1);

    // Reset in the middle of the data phase (after 7 beats)
    @(negedge clk); wr_trig = 1'b1;
    @(negedge clk); wr_trig = 1'b0; awready = 1'b0; wready = 1'b1;
    beats7 = 0;
    for (int cyc = 0; cyc < 50 && beats7 < 7; cyc++) begin
      #1;
      if (wvalid && wready) beats7++;
      @(negedge clk);
    end
    check("mid_beats", 64'(beats7), 64'd7);
    s_rst_n = 1'b0;
    #1;
    check("mid_rst_hs", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("mid_rst_cnt", 64'(wr_err_cnt), 64'd0);
    check("mid_rst_off", {8'd0, 28'(awaddr), 28'(araddr)}, {8'd0, 28'h10_0000, 28'h10_0000});
    wready = 1'b0;
    repeat (2) @(negedge clk);
    s_rst_n = 1'b1;
    wr_burst(0, 2'd0, 1'b0);
    check("rel_awaddr", 64'(wb_addr), 64'h10_0000);
    chk_wr("rel_b");
    rd_burst(0, 1'b0);
    settle();
    check("rel_araddr", 64'(rb_addr), 64'h10_0000);
    check("rel_start", 64'(n_start), 64'd2);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
